// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_digit_t;

    // Elaboration-time 10^n, used for the saturation threshold.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - one double-dabble correction cell: add 3 when the digit is 5 or more
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  bcd_digit_t d_i,
    output bcd_digit_t d_o
);

    always_comb begin
        d_o = d_i;
        if (d_i >= 4'd5) begin
            d_o = d_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - shift-and-add-3 binary-to-BCD converter, one shift per clock, saturating display
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int              BCD_W    = 4 * DIGITS;
    localparam int              CNT_W    = $clog2(IN_W + 1);
    localparam longint unsigned LIMIT    = pow10(DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

    state_e             state_q, state_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   scr_adj;
    logic [BCD_W-1:0]   scr_shift;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d_i (scr_q[4*g +: 4]),
            .d_o (scr_adj[4*g +: 4])
        );
    end

    // Carry out of the top digit is dropped; overflow was already decided at capture.
    assign scr_shift = {scr_adj[BCD_W-2:0], bin_q[IN_W-1]};

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d      = bin_in;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (64'(bin_in) >= LIMIT);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = scr_shift;
                bin_d = {bin_q[IN_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scr_shift;
                    ovf_d   = ovf_pend_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign bcd_out  = bcd_q;
    assign overflow = ovf_q;

endmodule
